rtc_calendar: RTL and testbench

Single-clock real-time clock and calendar for the UART IP system. It divides the system clock into a one-second tick and keeps seconds, minutes, hours, day, month and two-digit year with true month lengths and leap years. It generates a programmable periodic report pulse that the transmit path uses to schedule time-stamped frames. An edit mode lets the host set each field by increment strobes without carry.

---
 rtl/rtc_calendar.sv | 161 ++++++++++++++++
 tb/tb_rtc_calendar.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_calendar.sv
// rtl/rtc_calendar.sv - real-time clock/calendar with tick prescaler, periodic report pulse and field edit mode
module rtc_calendar #(
    parameter int DIV      = 50000000,
    parameter int PERIOD_S = 900,
    parameter int PULSE_W  = 2,
    parameter int FIXED_30 = 0
) (
    input  logic       MH50,
    input  logic       rst,
    input  logic       edit,
    input  logic       inc_sec,
    input  logic       inc_min,
    input  logic       inc_hour,
    input  logic       inc_day,
    input  logic       inc_mon,
    input  logic       inc_year,
    output logic [5:0] Hsec,
    output logic [5:0] Hmin,
    output logic [4:0] Hhour,
    output logic [4:0] Hday,
    output logic [3:0] Hmon,
    output logic [6:0] Hyear,
    output logic       tick,
    output logic       report
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int CW = (PERIOD_S > 1) ? $clog2(PERIOD_S) : 1;
    localparam int WW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

    localparam logic [PW-1:0] PRE_LAST   = PW'(DIV - 1);
    localparam logic [PW-1:0] PRE_PENULT = PW'(DIV - 2);
    localparam logic [CW-1:0] PER_LAST   = CW'(PERIOD_S - 1);
    localparam logic [WW-1:0] PULSE_LAST = WW'(PULSE_W - 1);

    logic [PW-1:0] presc;
    logic [CW-1:0] per_cnt;
    logic [WW-1:0] pulse_cnt;

    // Days in the given month; leap is true when the two-digit year is a multiple of 4.
    function automatic logic [4:0] month_days(input logic [3:0] mon, input logic leap);
        logic [4:0] d;
        if (FIXED_30 != 0) begin
            d = 5'd30;
        end else begin
            case (mon)
                4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
                4'd2:                    d = leap ? 5'd29 : 5'd28;
                default:                 d = 5'd31;
            endcase
        end
        return d;
    endfunction

    logic [5:0] e_sec, e_min, a_sec, a_min;
    logic [4:0] e_hour, e_day, e_mdays, a_hour, a_day, cur_mdays;
    logic [3:0] e_mon, a_mon;
    logic [6:0] e_year, a_year;
    logic       sec_wrap, min_wrap, hour_wrap, day_wrap, mon_wrap;

    // Edit-mode next values: independent wraps, day clamped against the updated month/year.
    always_comb begin
        e_sec   = inc_sec  ? ((Hsec  == 6'd59) ? 6'd0 : Hsec  + 6'd1) : Hsec;
        e_min   = inc_min  ? ((Hmin  == 6'd59) ? 6'd0 : Hmin  + 6'd1) : Hmin;
        e_hour  = inc_hour ? ((Hhour == 5'd23) ? 5'd0 : Hhour + 5'd1) : Hhour;
        e_mon   = inc_mon  ? ((Hmon  == 4'd12) ? 4'd1 : Hmon  + 4'd1) : Hmon;
        e_year  = inc_year ? ((Hyear == 7'd99) ? 7'd0 : Hyear + 7'd1) : Hyear;
        e_mdays = month_days(e_mon, e_year[1:0] == 2'b00);
        if ((inc_mon || inc_year) && (Hday > e_mdays)) begin
            e_day = e_mdays;
        end else if (inc_day) begin
            e_day = (Hday >= e_mdays) ? 5'd1 : Hday + 5'd1;
        end else begin
            e_day = Hday;
        end
    end

    // Timekeeping next values: one-second advance with full carry chain in a single edge.
    always_comb begin
        cur_mdays = month_days(Hmon, Hyear[1:0] == 2'b00);
        sec_wrap  = (Hsec == 6'd59);
        min_wrap  = sec_wrap && (Hmin == 6'd59);
        hour_wrap = min_wrap && (Hhour == 5'd23);
        day_wrap  = hour_wrap && (Hday >= cur_mdays);
        mon_wrap  = day_wrap && (Hmon == 4'd12);
        a_sec  = sec_wrap ? 6'd0 : Hsec + 6'd1;
        a_min  = sec_wrap  ? ((Hmin  == 6'd59) ? 6'd0 : Hmin  + 6'd1) : Hmin;
        a_hour = min_wrap  ? ((Hhour == 5'd23) ? 5'd0 : Hhour + 5'd1) : Hhour;
        a_day  = hour_wrap ? (day_wrap ? 5'd1 : Hday + 5'd1) : Hday;
        a_mon  = day_wrap  ? ((Hmon  == 4'd12) ? 4'd1 : Hmon  + 4'd1) : Hmon;
        a_year = mon_wrap  ? ((Hyear == 7'd99) ? 7'd0 : Hyear + 7'd1) : Hyear;
    end

    // Prescaler: tick is registered so it is high exactly while presc sits at DIV-1.
    always_ff @(posedge MH50 or posedge rst) begin
        if (rst) begin
            presc <= '0;
            tick  <= 1'b0;
        end else if (edit) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
            tick  <= (presc == PRE_PENULT);
        end
    end

    // Calendar fields: edit strobes while held, otherwise advance on each tick.
    always_ff @(posedge MH50 or posedge rst) begin
        if (rst) begin
            Hsec  <= 6'd0;
            Hmin  <= 6'd0;
            Hhour <= 5'd0;
            Hday  <= 5'd1;
            Hmon  <= 4'd1;
            Hyear <= 7'd0;
        end else if (edit) begin
            Hsec  <= e_sec;
            Hmin  <= e_min;
            Hhour <= e_hour;
            Hday  <= e_day;
            Hmon  <= e_mon;
            Hyear <= e_year;
        end else if (tick) begin
            Hsec  <= a_sec;
            Hmin  <= a_min;
            Hhour <= a_hour;
            Hday  <= a_day;
            Hmon  <= a_mon;
            Hyear <= a_year;
        end
    end

    // Report scheduler: count ticks per period and stretch the wrap into a PULSE_W-cycle pulse.
    always_ff @(posedge MH50 or posedge rst) begin
        if (rst) begin
            per_cnt   <= '0;
            pulse_cnt <= '0;
            report    <= 1'b0;
        end else if (edit) begin
            per_cnt   <= '0;
            pulse_cnt <= '0;
            report    <= 1'b0;
        end else begin
            if (tick) begin
                per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + 1'b1;
            end
            if (tick && (per_cnt == PER_LAST)) begin
                report    <= 1'b1;
                pulse_cnt <= PULSE_LAST;
            end else if (report) begin
                if (pulse_cnt == '0) begin
                    report <= 1'b0;
                end else begin
                    pulse_cnt <= pulse_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rtc_calendar.sv
// tb/tb_rtc_calendar.sv - self-checking bench for rtc_calendar against a behavioural calendar model
module tb_rtc_calendar;

    localparam int DIV      = 4;
    localparam int PERIOD_S = 3;
    localparam int PULSE_W  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       edit = 1'b0;
    logic [5:0] inc = 6'd0;

    logic [5:0] sec_o [2];
    logic [5:0] min_o [2];
    logic [4:0] hour_o[2];
    logic [4:0] day_o [2];
    logic [3:0] mon_o [2];
    logic [6:0] year_o[2];
    logic       tick_o[2];
    logic       report_o[2];

    int checks = 0;
    int failures = 0;

    // model state: index 0 real calendar, index 1 thirty-day months
    int m_sec[2], m_min[2], m_hour[2], m_day[2], m_mon[2], m_year[2];
    int n;
    bit edit_last;

    always #5 clk = ~clk;

    rtc_calendar #(.DIV(DIV), .PERIOD_S(PERIOD_S), .PULSE_W(PULSE_W), .FIXED_30(0)) u_real (
        .MH50(clk), .rst(rst), .edit(edit),
        .inc_sec(inc[0]), .inc_min(inc[1]), .inc_hour(inc[2]),
        .inc_day(inc[3]), .inc_mon(inc[4]), .inc_year(inc[5]),
        .Hsec(sec_o[0]), .Hmin(min_o[0]), .Hhour(hour_o[0]), .Hday(day_o[0]),
        .Hmon(mon_o[0]), .Hyear(year_o[0]), .tick(tick_o[0]), .report(report_o[0])
    );

    rtc_calendar #(.DIV(DIV), .PERIOD_S(PERIOD_S), .PULSE_W(PULSE_W), .FIXED_30(1)) u_fixed (
        .MH50(clk), .rst(rst), .edit(edit),
        .inc_sec(inc[0]), .inc_min(inc[1]), .inc_hour(inc[2]),
        .inc_day(inc[3]), .inc_mon(inc[4]), .inc_year(inc[5]),
        .Hsec(sec_o[1]), .Hmin(min_o[1]), .Hhour(hour_o[1]), .Hday(day_o[1]),
        .Hmon(mon_o[1]), .Hyear(year_o[1]), .tick(tick_o[1]), .report(report_o[1])
    );

    function automatic int mdays_m(int f, int mon, int year);
        if (f == 1) return 30;
        case (mon)
            2:             return (year % 4 == 0) ? 29 : 28;
            4, 6, 9, 11:   return 30;
            default:       return 31;
        endcase
    endfunction

    function automatic int exp_tick();
        if (edit_last) return 0;
        return (n % DIV == DIV - 1) ? 1 : 0;
    endfunction

    function automatic int exp_report();
        int k;
        if (edit_last) return 0;
        k = n / DIV;
        if (k < 1 || (k % PERIOD_S) != 0) return 0;
        return (n - (k * DIV - 1) <= PULSE_W) ? 1 : 0;
    endfunction

    function automatic int get_field(int idx);
        case (idx)
            0: return m_sec[0];
            1: return m_min[0];
            2: return m_hour[0];
            3: return m_day[0];
            4: return m_mon[0];
            default: return m_year[0];
        endcase
    endfunction

    task automatic model_reset();
        for (int f = 0; f < 2; f++) begin
            m_sec[f] = 0; m_min[f] = 0; m_hour[f] = 0;
            m_day[f] = 1; m_mon[f] = 1; m_year[f] = 0;
        end
        n = 0;
        edit_last = 1'b0;
    endtask

    task automatic model_advance(int f);
        m_sec[f]++;
        if (m_sec[f] == 60) begin
            m_sec[f] = 0; m_min[f]++;
            if (m_min[f] == 60) begin
                m_min[f] = 0; m_hour[f]++;
                if (m_hour[f] == 24) begin
                    m_hour[f] = 0; m_day[f]++;
                    if (m_day[f] > mdays_m(f, m_mon[f], m_year[f])) begin
                        m_day[f] = 1; m_mon[f]++;
                        if (m_mon[f] == 13) begin
                            m_mon[f] = 1;
                            m_year[f] = (m_year[f] + 1) % 100;
                        end
                    end
                end
            end
        end
    endtask

    task automatic model_edit(int f, logic [5:0] v);
        int md;
        if (v[0]) m_sec[f]  = (m_sec[f] + 1) % 60;
        if (v[1]) m_min[f]  = (m_min[f] + 1) % 60;
        if (v[2]) m_hour[f] = (m_hour[f] + 1) % 24;
        if (v[4]) m_mon[f]  = m_mon[f] % 12 + 1;
        if (v[5]) m_year[f] = (m_year[f] + 1) % 100;
        md = mdays_m(f, m_mon[f], m_year[f]);
        if ((v[4] || v[5]) && m_day[f] > md) m_day[f] = md;
        else if (v[3]) m_day[f] = (m_day[f] >= md) ? 1 : m_day[f] + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int f = 0; f < 2; f++) begin
            chk($sformatf("sec%0d", f),    32'(sec_o[f]),    32'(m_sec[f]));
            chk($sformatf("min%0d", f),    32'(min_o[f]),    32'(m_min[f]));
            chk($sformatf("hour%0d", f),   32'(hour_o[f]),   32'(m_hour[f]));
            chk($sformatf("day%0d", f),    32'(day_o[f]),    32'(m_day[f]));
            chk($sformatf("mon%0d", f),    32'(mon_o[f]),    32'(m_mon[f]));
            chk($sformatf("year%0d", f),   32'(year_o[f]),   32'(m_year[f]));
            chk($sformatf("tick%0d", f),   32'(tick_o[f]),   32'(exp_tick()));
            chk($sformatf("report%0d", f), 32'(report_o[f]), 32'(exp_report()));
        end
    endtask

    // one clock edge: advance the model with the current inputs, then compare after the edge
    task automatic step();
        int tk;
        tk = exp_tick();
        if (edit) begin
            for (int f = 0; f < 2; f++) model_edit(f, inc);
            n = 0;
            edit_last = 1'b1;
        end else begin
            if (tk != 0) for (int f = 0; f < 2; f++) model_advance(f);
            n++;
            edit_last = 1'b0;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic pulse(input logic [5:0] v);
        inc = v;
        step();
        inc = 6'd0;
    endtask

    task automatic set_field(int idx, int target);
        for (int i = 0; i < 200 && get_field(idx) != target; i++) pulse(6'(1 << idx));
        chk($sformatf("set_field%0d", idx), 32'(get_field(idx) == target), 32'd1);
    endtask

    // assert reset between edges and confirm it acts without waiting for a clock
    task automatic do_reset();
        edit = 1'b0;
        inc = 6'd0;
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        rst = 1'b0;
    endtask

    task automatic set_time(int y, int mo, int d, int h, int mi, int s);
        edit = 1'b1;
        step();
        set_field(5, y);
        set_field(4, mo);
        set_field(3, d);
        set_field(2, h);
        set_field(1, mi);
        set_field(0, s);
    endtask

    initial begin
        int day_before;
        int len;
        model_reset();

        // reset values while rst is held across edges
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // reset and rollover: 12 cycles, ticks at 3/7/11, report after the 3rd and 6th tick
        repeat (12) step();
        chk("sec_after_12", 32'(sec_o[0]), 32'd3);
        chk("report_c12", 32'(report_o[0]), 32'd1);
        step();
        chk("report_c13", 32'(report_o[0]), 32'd1);
        step();
        chk("report_c14", 32'(report_o[0]), 32'd0);
        repeat (10) step();
        chk("report_c24", 32'(report_o[0]), 32'd1);

        // async reset mid-report
        #1;
        rst = 1'b1;
        #1;
        chk("async_report", 32'(report_o[0]), 32'd0);
        chk("async_day",    32'(day_o[0]),    32'd1);
        chk("async_mon",    32'(mon_o[0]),    32'd1);
        model_reset();
        check_all();
        #1;
        rst = 1'b0;

        // edit hold from prescaler=2, then hour wrap without carry, then ignored strobes
        for (int i = 0; i < 2 * DIV && (n % DIV) != 2; i++) step();
        chk("presc_at_2", 32'(n % DIV), 32'd2);
        edit = 1'b1;
        repeat (10) step();
        set_field(2, 23);
        day_before = m_day[0];
        pulse(6'b000100);
        chk("hour_wrap_edit", 32'(hour_o[0]), 32'd0);
        chk("hour_wrap_day",  32'(day_o[0]),  32'(day_before));
        edit = 1'b0;
        inc = 6'h3f;
        step();
        inc = 6'd0;
        step();
        chk("ignored_hour", 32'(hour_o[0]), 32'd0);

        // day clamp: Jan 31 + inc_mon + inc_day in year 0
        do_reset();
        set_time(0, 1, 31, 5, 6, 7);
        pulse(6'b011000);
        chk("clamp_mon", 32'(mon_o[0]), 32'd2);
        chk("clamp_day", 32'(day_o[0]), 32'd29);
        chk("clamp_hour", 32'(hour_o[0]), 32'd5);

        // leap February, year 4
        do_reset();
        set_time(4, 2, 28, 23, 59, 59);
        edit = 1'b0;
        repeat (DIV) step();
        chk("leap_day",   32'(day_o[0]), 32'd29);
        chk("leap_mon",   32'(mon_o[0]), 32'd2);
        chk("fixed_day4", 32'(day_o[1]), 32'd29);

        // non-leap February, year 5
        do_reset();
        set_time(5, 2, 28, 23, 59, 59);
        edit = 1'b0;
        repeat (DIV) step();
        chk("nonleap_day", 32'(day_o[0]), 32'd1);
        chk("nonleap_mon", 32'(mon_o[0]), 32'd3);
        chk("fixed_day5",  32'(day_o[1]), 32'd29);

        // full rollover 31 Dec 99 23:59:59
        do_reset();
        set_time(99, 12, 31, 23, 59, 59);
        edit = 1'b0;
        repeat (DIV) step();
        chk("roll_sec",  32'(sec_o[0]),  32'd0);
        chk("roll_min",  32'(min_o[0]),  32'd0);
        chk("roll_hour", 32'(hour_o[0]), 32'd0);
        chk("roll_day",  32'(day_o[0]),  32'd1);
        chk("roll_mon",  32'(mon_o[0]),  32'd1);
        chk("roll_year", 32'(year_o[0]), 32'd0);

        // randomized mix of free running, random edit strobes and near-rollover starts
        for (int it = 0; it < 40; it++) begin
            len = $urandom_range(1, 60);
            case ($urandom_range(0, 2))
                0: begin
                    edit = 1'b0;
                    for (int c = 0; c < len; c++) begin
                        inc = 6'($urandom);
                        step();
                    end
                end
                1: begin
                    edit = 1'b1;
                    for (int c = 0; c < len; c++) begin
                        inc = 6'($urandom) & 6'($urandom) & 6'($urandom);
                        step();
                    end
                end
                default: begin
                    set_time($urandom_range(0, 99), $urandom_range(1, 12), 1, 23, 59,
                             $urandom_range(50, 59));
                    set_field(3, mdays_m(0, m_mon[0], m_year[0]) - $urandom_range(0, 1));
                    edit = 1'b0;
                    for (int c = 0; c < len + 40; c++) step();
                end
            endcase
            inc = 6'd0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
